pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised program-counter generator for the IF stage. It is the successor of the single-width PC register.
- Adds a configurable address width, reset vector and fetch step, and a two-level redirect priority (exception over branch).
- Redirects that arrive while the PC cannot advance are held and applied at the next advance, never dropped.
- Adds a fetch-ready handshake toward instruction memory and reports misaligned redirect targets.

Parameters:
ADDR_W, 32, PC/address width in bits (>= 8)
RESET_VEC, 0, PC value during and immediately after reset; must be STEP-aligned
STEP, 4, byte increment per sequential fetch; power of two, 2..16

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
stall  input  1  pipeline stall; PC holds
if_ready  input  1  instruction memory accepts the current fetch this cycle
exc_flag_i  input  1  exception/trap redirect request, highest priority
exc_addr_i  input  ADDR_W  exception target
branch_flag_i  input  1  branch/jump redirect request
branch_addr_i  input  ADDR_W  branch target
pc  output  ADDR_W  current fetch address
pc_next_seq  output  ADDR_W  pc + STEP, combinational, modulo 2^ADDR_W
ce  output  1  fetch enable / request to instruction memory
redir_pending  output  1  a redirect is held, waiting for advance
misalign  output  1  one-cycle pulse: accepted redirect target not STEP-aligned

Behaviour:
- Reset: clock and reset as above; reset is synchronous and active-low. While rst=0 at a clock edge: ce<=0, pc<=RESET_VEC, redir_pending<=0, pending target<=0, misalign<=0. Reset mid-operation discards any pending redirect.
- ce: registered. It goes 1 on the first edge with rst=1 and stays 1 until the next reset. While ce=0, pc stays RESET_VEC.
- advance = ce & ~stall & if_ready. The PC changes only when advance=1.
- Next-PC priority when advance=1, highest first:
  1. exc_flag_i -> exc_addr_i
  2. branch_flag_i -> branch_addr_i
  3. redir_pending -> held target
  4. otherwise pc_next_seq
- Any advance clears redir_pending.
- When advance=0 and ce=1:
  - exc_flag_i=1: capture exc_addr_i into the held target and set redir_pending. This overwrites a held branch.
  - else branch_flag_i=1 and the held entry is not an exception: capture branch_addr_i and set redir_pending. A newer branch overwrites an older held branch.
  - A held exception is never overwritten by a branch. One internal bit records whether the held entry is an exception.
- Redirect flags arriving while ce=0 are ignored.
- Misalignment:
  - The PC is loaded with the full target unmodified; no masking of the low bits.
  - misalign is registered. It is 1 for exactly the cycle after an advance that loaded a redirect target (from priority levels 1-3) whose low log2(STEP) bits are nonzero. Otherwise it is 0.
  - Sequential advances never assert misalign.
- Wrap-around: pc_next_seq wraps modulo 2^ADDR_W with no flag. 2^ADDR_W-STEP advances to 0.
- Simultaneous events:
  - exc_flag_i and branch_flag_i together: the exception wins and the branch is discarded.
  - stall=1 with if_ready=1: hold.
  - stall=0 with if_ready=0: hold.
- Latency: a redirect asserted in the cycle with advance=1 appears on pc after the next edge (1 cycle). A held redirect appears after the edge of the first cycle with advance=1.

Test Plan:
- Reset and start: rst=0 for 3 cycles, RESET_VEC=32'h100, then rst=1, stall=0, if_ready=1 -> ce=0 and pc=0x100 during reset; ce=1 after the first released edge; pc then steps 0x100, 0x104, 0x108.
- Stall with branch: at pc=0x20 assert stall=1 plus a 1-cycle branch to 0x80 -> pc holds 0x20 and redir_pending=1; drop stall -> pc=0x80 after the next edge, then 0x84; redir_pending=0.
- Priority: exc_flag_i (0x1000) and branch_flag_i (0x200) in the same advancing cycle -> pc=0x1000 next cycle. Held exception 0x1000, then a branch to 0x300 while if_ready=0 -> the held target stays 0x1000.
- Backpressure: if_ready=0 for 4 cycles at pc=0x40 -> pc holds 0x40. Two successive branches in that window (0x60, then 0x70) -> pc=0x70 on release.
- Misalign and wrap: ADDR_W=16, branch to 16'h0082 -> misalign=1 for one cycle, pc=0x0082. Separately, pc=16'hFFFC with a sequential advance -> pc=0x0000, misalign=0.
- Reset mid-operation: redirect held, then rst=0 for one edge -> pc=RESET_VEC, redir_pending=0, ce=0; the held target is not applied after release.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: sequential stepping, exception/branch
// redirects with a single held slot while the PC cannot advance, and misalignment reporting.
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              if_ready,
  input  logic              exc_flag_i,
  input  logic [ADDR_W-1:0] exc_addr_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              ce,
  output logic              redir_pending,
  output logic              misalign
);

  localparam int                SH     = $clog2(STEP);
  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_target;
  logic              r_ce;
  logic              r_pend;
  logic              r_pend_exc;
  logic              r_misalign;

  logic              w_advance;
  logic              w_redir_valid;
  logic [ADDR_W-1:0] w_redir_addr;
  logic [ADDR_W-1:0] w_pc_next_seq;
  logic              w_redir_misaligned;

  assign w_advance     = r_ce & ~stall & if_ready;
  assign w_pc_next_seq = r_pc + STEP_W;

  // Redirect source in priority order: live exception, live branch, held entry.
  always_comb begin
    w_redir_valid = 1'b0;
    w_redir_addr  = '0;
    if (exc_flag_i) begin
      w_redir_valid = 1'b1;
      w_redir_addr  = exc_addr_i;
    end else if (branch_flag_i) begin
      w_redir_valid = 1'b1;
      w_redir_addr  = branch_addr_i;
    end else if (r_pend) begin
      w_redir_valid = 1'b1;
      w_redir_addr  = r_target;
    end
  end

  assign w_redir_misaligned = w_redir_valid && (w_redir_addr[SH-1:0] != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ce       <= 1'b0;
      r_pc       <= RESET_VEC;
      r_pend     <= 1'b0;
      r_pend_exc <= 1'b0;
      r_target   <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_ce       <= 1'b1;
      r_misalign <= 1'b0;
      if (w_advance) begin
        r_pc       <= w_redir_valid ? w_redir_addr : w_pc_next_seq;
        r_misalign <= w_redir_misaligned;
        r_pend     <= 1'b0;
        r_pend_exc <= 1'b0;
      end else if (r_ce) begin
        // A held exception is sticky against later branches; a newer exception replaces anything.
        if (exc_flag_i) begin
          r_target   <= exc_addr_i;
          r_pend     <= 1'b1;
          r_pend_exc <= 1'b1;
        end else if (branch_flag_i && !(r_pend && r_pend_exc)) begin
          r_target   <= branch_addr_i;
          r_pend     <= 1'b1;
          r_pend_exc <= 1'b0;
        end
      end
    end
  end

  assign pc            = r_pc;
  assign pc_next_seq   = w_pc_next_seq;
  assign ce            = r_ce;
  assign redir_pending = r_pend;
  assign misalign      = r_misalign;

endmodule
